// File: rtl/fifo_stream_pkg.sv
// Shared types and helpers for the FIFO read streamer.
// Contents: FSM state enum, default data width, and a pointer-wrap
// increment used by the circular output buffer.
package fifo_stream_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int DATA_W_DEF = 8;

  // Next pointer value for a circular buffer of 'depth' entries.
  function automatic int unsigned ptr_wrap_inc(input int unsigned ptr,
                                               input int unsigned depth);
    return (ptr + 1 >= depth) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/stream_out_buf.sv
// Circular output buffer feeding a valid/ready stream.
// Ports:
//   i_clk, i_rst   clock, async active-high reset
//   i_flush        drop all entries (wins over push/pop)
//   i_push/i_data  write i_data at tail
//   i_pop          consume entry at head (ignored when empty)
//   o_count        occupied entries
//   o_valid        o_count != 0
//   o_data         entry at head
module stream_out_buf import fifo_stream_pkg::*; #(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int BUF_DEPTH = 4
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic                             i_flush,
  input  logic                             i_push,
  input  logic [DATA_W-1:0]                i_data,
  input  logic                             i_pop,
  output logic [$clog2(BUF_DEPTH+1)-1:0]   o_count,
  output logic                             o_valid,
  output logic [DATA_W-1:0]                o_data
);

  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W = $clog2(BUF_DEPTH+1);

  logic [DATA_W-1:0] r_mem [BUF_DEPTH];
  logic [PTR_W-1:0]  r_head, r_tail;
  logic [CNT_W-1:0]  r_count;
  logic              w_pop;

  assign w_pop   = i_pop && (r_count != '0);
  assign o_count = r_count;
  assign o_valid = (r_count != '0);
  assign o_data  = r_mem[r_head];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      // Cleared so the stream data output reads zero out of reset.
      for (int i = 0; i < BUF_DEPTH; i++) r_mem[i] <= '0;
    end else if (i_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_tail] <= i_data;
        r_tail        <= PTR_W'(ptr_wrap_inc(32'(r_tail), BUF_DEPTH));
      end
      if (w_pop)
        r_head <= PTR_W'(ptr_wrap_inc(32'(r_head), BUF_DEPTH));
      case ({i_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Upstream credit accounting must make a push into a full buffer impossible.
  assert property (@(posedge i_clk) disable iff (i_rst)
    !(i_push && !w_pop && !i_flush && (r_count == CNT_W'(BUF_DEPTH))));

endmodule

// File: rtl/fifo_read_streamer.sv
// Read-side master for an 8-bit style FIFO port set. Issues reads while
// buffer credits allow, absorbs the FIFO read latency with a valid shift
// register and presents the words as a valid/ready stream, in FIFO order.
// Ports:
//   clk, rst          clock, async active-high reset
//   en                1 = fetch, 0 = stop fetching and drain
//   flush             pulse: discard buffered and in-flight words
//   empty             FIFO empty flag (registered in the FIFO)
//   rd_cs, rd_en      FIFO read strobes
//   data_out          FIFO read data, valid RD_LAT cycles after a read
//   m_valid/m_ready/m_data  output stream
//   busy              state != IDLE
//   word_cnt          delivered words, wraps
module fifo_read_streamer import fifo_stream_pkg::*; #(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int RD_LAT    = 1,
  parameter int BUF_DEPTH = 4,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              flush,
  input  logic              empty,
  output logic              rd_cs,
  output logic              rd_en,
  input  logic [DATA_W-1:0] data_out,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              busy,
  output logic [CNT_W-1:0]  word_cnt
);

  localparam int BCNT_W = $clog2(BUF_DEPTH+1);

  state_t            r_state, w_state_nxt;
  logic [RD_LAT-1:0] r_vld_pipe;
  logic [CNT_W-1:0]  r_word_cnt;
  logic [BCNT_W-1:0] w_count;
  int unsigned       w_inflight;
  logic              w_issue, w_push, w_pop;

  always_comb begin
    w_inflight = 0;
    for (int i = 0; i < RD_LAT; i++) w_inflight += 32'(r_vld_pipe[i]);
  end

  // Credits count both buffered and in-flight words, so a read is only
  // issued when its data is guaranteed a slot. Depends on registered
  // state only: m_ready has no path to rd_en.
  assign w_issue = (r_state == RUN) && !empty && !flush &&
                   ((32'(w_count) + w_inflight) < 32'(BUF_DEPTH));
  assign rd_cs   = w_issue;
  assign rd_en   = w_issue;

  assign w_push  = r_vld_pipe[RD_LAT-1];
  assign w_pop   = m_valid && m_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        r_vld_pipe <= '0;
    else if (flush) r_vld_pipe <= '0;
    // Concatenate-and-truncate shift works for RD_LAT == 1 as well.
    else            r_vld_pipe <= RD_LAT'({r_vld_pipe, w_issue});
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (flush) w_state_nxt = IDLE;
    else begin
      case (r_state)
        IDLE:    if (en) w_state_nxt = RUN;
        RUN:     if (!en) w_state_nxt = DRAIN;
        DRAIN:   if (en) w_state_nxt = RUN;
                 else if (w_inflight == 0 && w_count == '0) w_state_nxt = IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        r_word_cnt <= '0;
    else if (w_pop) r_word_cnt <= r_word_cnt + CNT_W'(1);
  end

  assign busy     = (r_state != IDLE);
  assign word_cnt = r_word_cnt;

  stream_out_buf #(
    .DATA_W    (DATA_W),
    .BUF_DEPTH (BUF_DEPTH)
  ) u_buf (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_flush (flush),
    .i_push  (w_push),
    .i_data  (data_out),
    .i_pop   (w_pop),
    .o_count (w_count),
    .o_valid (m_valid),
    .o_data  (m_data)
  );

endmodule

// File: doc/fifo_read_streamer.md
Name: fifo_read_streamer

Overview:
- Read-side master for the 8-bit FIFO port set (empty, rd_cs, rd_en, data_out).
- Pulls words from the FIFO, absorbs the FIFO's fixed read latency and forwards the data as a valid/ready stream to downstream logic.
- Counterpart of the write-side driver: whatever is pushed through wr_cs/wr_en/data_in is drained here in order, with no loss or duplication.

Parameters:
- DATA_W, 8: FIFO data and stream width.
- RD_LAT, 1: cycles from a rd_cs&rd_en sample to valid data_out. Legal values are 1 or 2.
- BUF_DEPTH, 4: output buffer entries. Must be at least RD_LAT+1. BUF_DEPTH >= RD_LAT+2 is required for 1 word/cycle throughput.
- CNT_W, 16: width of the delivered-word counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- en  in  1  run request. Level: 1 = fetch, 0 = stop fetching and drain.
- flush  in  1  single-cycle pulse; discards buffered and in-flight words.
- empty  in  1  FIFO empty flag, registered in the FIFO.
- rd_cs  out  1  FIFO read chip select.
- rd_en  out  1  FIFO read enable.
- data_out  in  DATA_W  FIFO read data.
- m_valid  out  1  stream word valid.
- m_ready  in  1  downstream accept.
- m_data  out  DATA_W  stream word.
- busy  out  1  state != IDLE.
- word_cnt  out  CNT_W  words delivered (m_valid&m_ready), wraps modulo 2^CNT_W.

Behaviour:
- Reset (async, while rst=1):
  - state=IDLE, buffer empty, in-flight pipeline cleared, word_cnt=0.
  - m_valid=0, m_data=0, rd_cs=0, rd_en=0, busy=0.
  - Reset mid-operation: in-flight words are lost and no later data_out is captured.
- FSM:
  - IDLE -> RUN when en=1.
  - RUN -> DRAIN when en=0.
  - DRAIN -> RUN when en=1.
  - DRAIN -> IDLE when inflight==0 and count==0.
  - flush in any state forces IDLE next cycle.
- Read issue, combinational from registered state and empty:
  - issue = (state==RUN) & !empty & !flush & (count+inflight < BUF_DEPTH).
  - rd_cs = rd_en = issue.
  - No combinational path from m_ready to rd_en.
- In-flight tracking:
  - RD_LAT-stage valid shift register.
  - data_out is captured into the buffer tail exactly RD_LAT cycles after issue.
  - inflight = popcount of the shift register.
- Buffer:
  - Circular, BUF_DEPTH entries, registered head/tail pointers that wrap at BUF_DEPTH, count register.
  - m_valid = count!=0; m_data = entry at head.
  - Push and pop in the same cycle leave count unchanged.
  - Overflow cannot occur because of the credit rule. Assert push & count==BUF_DEPTH & !pop never happens.
- Ordering: words leave in exactly the FIFO read order.
- Stream rule: once m_valid=1, m_valid and m_data stay stable until m_ready=1 (except flush/rst).
- Flush:
  - Next cycle: count=0, head=tail=0, valid shift register cleared.
  - Returning in-flight data is dropped (FIFO words are consumed, not re-delivered).
  - word_cnt is unaffected.
- empty=1 with credits available: no read. The next read is issued in the first cycle empty=0.
- word_cnt increments on every m_valid&m_ready and wraps 0xFFFF -> 0x0000.

Decomposition:
- Package fifo_stream_pkg:
  - state enum (IDLE, RUN, DRAIN).
  - DATA_W default constant.
  - Helper function for the pointer-wrap increment.
- One sub-module, stream_out_buf: circular buffer with push, pop, count, head data, parameterized by DATA_W and BUF_DEPTH.
- Top holds the FSM, issue/credit logic, latency pipeline and counter.

Test Plan:
1. Reset, FIFO preloaded with 0x11..0x18, en=1, m_ready=1 -> rd_en high 8 consecutive cycles; m_data 0x11..0x18 back-to-back starting RD_LAT+1 cycles after the first rd_en; word_cnt=8; busy drops after en=0.
2. Same preload, m_ready=0 for 10 cycles -> exactly BUF_DEPTH (4) reads issued, then rd_en=0; m_valid held with m_data=0x11; releasing m_ready delivers 0x11..0x18 in order, no duplicates.
3. FIFO empty, en=1 for 5 cycles, then one word 0xA5 written -> rd_en=0 while empty=1, a single read the cycle empty falls, m_data=0xA5.
4. en drops while 2 words in flight/buffered -> state DRAIN, no further rd_en, both words delivered, then state IDLE and busy=0.
5. flush pulsed the cycle after a read issue with 2 words buffered -> m_valid=0 next cycle, the in-flight word never appears on m_data, word_cnt unchanged.
6. Preload word_cnt to 0xFFFE via 0xFFFE transfers (or a forced bench state), deliver 3 words -> word_cnt 0xFFFF, 0x0000, 0x0001; rst asserted mid-stream clears m_valid and word_cnt asynchronously.
